fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/spu_pkg.sv | 50 +++++
 rtl/spu_alu.sv | 29 ++
 rtl/fetch_sequencer.sv | 118 +++++++++++
 tb/tb_fetch_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// spu_pkg: opcodes, sequencer state encoding and instruction field helpers
// shared by the fetch sequencer, its ALU and the bench.
`default_nettype none

package spu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_ADDI = 4'd5,
        OP_BEQ  = 4'd6,
        OP_JMP  = 4'd7,
        OP_HALT = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 12;
    localparam int RD_MSB    = 11;
    localparam int RD_LSB    = 9;
    localparam int RS1_MSB   = 8;
    localparam int RS1_LSB   = 6;
    localparam int RS2_MSB   = 5;
    localparam int RS2_LSB   = 3;
    localparam int IMM6_MSB  = 5;
    localparam int IMM12_MSB = 11;

    function automatic logic [15:0] sext_imm6(input logic [5:0] imm);
        return {{10{imm[5]}}, imm};
    endfunction

    function automatic logic writes_reg(input opcode_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_ADDI);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spu_alu.sv
// spu_alu: combinational 16-bit ALU with an operand-equality flag for branches.
`default_nettype none

module spu_alu
    import spu_pkg::*;
(
    input  opcode_e     op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result,
    output logic        equal
);

    always_comb begin
        result = 16'h0000;
        case (op)
            OP_ADD, OP_ADDI: result = a + b;
            OP_SUB, OP_BEQ:  result = a - b;
            OP_AND:          result = a & b;
            OP_OR:           result = a | b;
            default:         result = 16'h0000;
        endcase
    end

    assign equal = (a == b);

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle fetch/decode/execute/writeback controller for
// the 16-bit SPU core, driving the instruction cache and register-file ports.
`default_nettype none

module fetch_sequencer
    import spu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_STEP  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [15:0] counter,
    output logic        fetch_req,
    input  logic        fetch_ack,
    input  logic [15:0] instruction,
    output logic [2:0]  reg_read_address_1,
    output logic [2:0]  reg_read_address_2,
    input  logic [15:0] reg_read_data_1,
    input  logic [15:0] reg_read_data_2,
    output logic        reg_write_enable,
    output logic [2:0]  reg_write_destination,
    output logic [15:0] reg_write_data,
    output logic        halted
);

    localparam logic [15:0] PC_INC = 16'(PC_STEP);

    state_e      state;
    state_e      state_next;
    logic [15:0] ir;
    opcode_e     op;
    logic [15:0] imm6_ext;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        alu_equal;
    logic        branch_taken;
    logic [15:0] next_pc;

    assign op       = opcode_e'(ir[OPC_MSB:OPC_LSB]);
    assign imm6_ext = sext_imm6(ir[IMM6_MSB:0]);
    assign alu_b    = (op == OP_ADDI) ? imm6_ext : reg_read_data_2;

    spu_alu u_alu (
        .op     (op),
        .a      (reg_read_data_1),
        .b      (alu_b),
        .result (alu_result),
        .equal  (alu_equal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (run) state_next = ST_FETCH;
            ST_FETCH:     if (fetch_ack) state_next = ST_DECODE;
            ST_DECODE:    state_next = ST_EXECUTE;
            ST_EXECUTE:   state_next = (op == OP_HALT) ? ST_HALT : ST_WRITEBACK;
            ST_WRITEBACK: state_next = run ? ST_FETCH : ST_IDLE;
            ST_HALT:      state_next = ST_HALT;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Branch target is relative to the BEQ's own address plus one word.
    always_comb begin
        next_pc = counter + PC_INC;
        case (op)
            OP_BEQ:  if (branch_taken) next_pc = counter + 16'd2 + {imm6_ext[14:0], 1'b0};
            OP_JMP:  next_pc = {3'b000, ir[IMM12_MSB:0], 1'b0};
            default: next_pc = counter + PC_INC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter        <= RESET_PC;
            ir             <= 16'h0000;
            reg_write_data <= 16'h0000;
            branch_taken   <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (fetch_ack) ir <= instruction;
                end
                ST_EXECUTE: begin
                    reg_write_data <= alu_result;
                    branch_taken   <= (op == OP_BEQ) && alu_equal;
                end
                ST_WRITEBACK: begin
                    counter <= next_pc;
                end
                default: ;
            endcase
        end
    end

    // Register selects come straight from IR, so they stay valid from
    // DECODE until the next instruction is latched.
    assign reg_read_address_1    = ir[RS1_MSB:RS1_LSB];
    assign reg_read_address_2    = ir[RS2_MSB:RS2_LSB];
    assign reg_write_destination = ir[RD_MSB:RD_LSB];
    assign reg_write_enable      = (state == ST_WRITEBACK) && writes_reg(op);
    assign fetch_req             = (state == ST_FETCH);
    assign halted                = (state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven program run with a write scoreboard, plus
// hand-written halt and reset-during-fetch sequences.
`default_nettype none

module tb_fetch_sequencer;
    import spu_pkg::*;

    typedef struct {
        logic [15:0] ins;
        int          delay;
        logic        we;
        logic [2:0]  dest;
        logic [15:0] data;
        logic [15:0] next_pc;
        logic        halt;
    } vec_t;

    typedef struct {
        logic        we;
        logic [2:0]  dest;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [15:0] counter;
    logic        fetch_req;
    logic        fetch_ack;
    logic [15:0] instruction;
    logic [2:0]  reg_read_address_1;
    logic [2:0]  reg_read_address_2;
    logic [15:0] reg_read_data_1;
    logic [15:0] reg_read_data_2;
    logic        reg_write_enable;
    logic [2:0]  reg_write_destination;
    logic [15:0] reg_write_data;
    logic        halted;

    logic [15:0] imem [16];
    logic [15:0] rf [8];
    exp_t        exp_q [$];
    vec_t        vecs [15];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    fetch_sequencer #(.RESET_PC(16'h0000), .PC_STEP(2)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .run                   (run),
        .counter               (counter),
        .fetch_req             (fetch_req),
        .fetch_ack             (fetch_ack),
        .instruction           (instruction),
        .reg_read_address_1    (reg_read_address_1),
        .reg_read_address_2    (reg_read_address_2),
        .reg_read_data_1       (reg_read_data_1),
        .reg_read_data_2       (reg_read_data_2),
        .reg_write_enable      (reg_write_enable),
        .reg_write_destination (reg_write_destination),
        .reg_write_data        (reg_write_data),
        .halted                (halted)
    );

    always #5 clk = ~clk;

    assign instruction     = imem[counter[4:1]];
    assign reg_read_data_1 = rf[reg_read_address_1];
    assign reg_read_data_2 = rf[reg_read_address_2];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
        end else if (reg_write_enable) begin
            rf[reg_write_destination] <= reg_write_data;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input vec_t v);
        int cyc;
        logic [15:0] pc0;
        bit seen;
        imem[counter[4:1]] = v.ins;
        if (!v.halt) exp_q.push_back('{v.we, v.dest, v.data});
        run = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = fetch_req;
        end
        if (!seen) begin
            check("fetch_req_timeout", 16'(fetch_req), 16'h1);
            return;
        end
        pc0 = counter;
        cyc = 0;
        for (int i = 0; i < v.delay; i++) begin
            tick();
            cyc++;
            check("fetch_req_held", 16'(fetch_req), 16'h1);
            check("counter_stable", counter, pc0);
        end
        fetch_ack = 1'b1;
        run = 1'b0;
        tick();
        cyc++;
        fetch_ack = 1'b0;
        check("decode_rs1", 16'(reg_read_address_1), 16'(v.ins[8:6]));
        check("decode_rs2", 16'(reg_read_address_2), 16'(v.ins[5:3]));
        tick();
        cyc++;
        check("execute_we_low", 16'(reg_write_enable), 16'h0);
        if (v.halt) begin
            tick();
            check("halted", 16'(halted), 16'h1);
            check("halt_counter", counter, v.next_pc);
            return;
        end
        tick();
        cyc++;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 16'h0, 16'h1);
        end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("wb_we", 16'(reg_write_enable), 16'(e.we));
            if (e.we) begin
                check("wb_dest", 16'(reg_write_destination), 16'(e.dest));
                check("wb_data", reg_write_data, e.data);
            end
        end
        tick();
        cyc++;
        check("next_pc", counter, v.next_pc);
        check("latency", 16'(cyc), 16'(v.delay + 4));
        check("we_after_wb", 16'(reg_write_enable), 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t nop_v;
        for (int i = 0; i < 16; i++) imem[i] = 16'h0000;
        //          ins       dly we  rd    data      next_pc   halt
        vecs[0]  = '{16'h5205, 0, 1, 3'd1, 16'h0005, 16'h0002, 0};
        vecs[1]  = '{16'h543E, 0, 1, 3'd2, 16'hFFFE, 16'h0004, 0};
        vecs[2]  = '{16'h1650, 3, 1, 3'd3, 16'h0003, 16'h0006, 0};
        vecs[3]  = '{16'h5E05, 0, 1, 3'd7, 16'h0005, 16'h0008, 0};
        vecs[4]  = '{16'h607E, 0, 0, 3'd0, 16'h0000, 16'h0006, 0};
        vecs[5]  = '{16'h2850, 1, 1, 3'd4, 16'h0007, 16'h0008, 0};
        vecs[6]  = '{16'h6050, 0, 0, 3'd0, 16'h0000, 16'h000A, 0};
        vecs[7]  = '{16'h3A50, 0, 1, 3'd5, 16'h0004, 16'h000C, 0};
        vecs[8]  = '{16'h4C50, 2, 1, 3'd6, 16'hFFFF, 16'h000E, 0};
        vecs[9]  = '{16'h8000, 0, 0, 3'd0, 16'h0000, 16'h0010, 0};
        vecs[10] = '{16'h77FF, 0, 0, 3'd0, 16'h0000, 16'h0FFE, 0};
        vecs[11] = '{16'h5003, 0, 1, 3'd0, 16'h0003, 16'h1000, 0};
        vecs[12] = '{16'h1400, 0, 1, 3'd2, 16'h0006, 16'h1002, 0};
        vecs[13] = '{16'h7002, 0, 0, 3'd0, 16'h0000, 16'h0004, 0};
        vecs[14] = '{16'hF000, 0, 0, 3'd0, 16'h0000, 16'h0004, 1};

        rst = 1'b1;
        run = 1'b0;
        fetch_ack = 1'b0;
        tick();
        tick();
        check("rst_counter", counter, 16'h0000);
        check("rst_fetch_req", 16'(fetch_req), 16'h0);
        check("rst_halted", 16'(halted), 16'h0);
        check("rst_we", 16'(reg_write_enable), 16'h0);
        check("rst_dest", 16'(reg_write_destination), 16'h0);
        check("rst_data", reg_write_data, 16'h0000);
        check("rst_rs1", 16'(reg_read_address_1), 16'h0);
        check("rst_rs2", 16'(reg_read_address_2), 16'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) run_instr(vecs[i]);

        // HALT is sticky: run must not restart fetching.
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("halt_no_fetch", 16'(fetch_req), 16'h0);
        end
        check("halt_still_halted", 16'(halted), 16'h1);
        check("halt_still_counter", counter, 16'h0004);
        run = 1'b0;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_leaves_halt", 16'(halted), 16'h0);
        nop_v = '{16'h0000, 0, 0, 3'd0, 16'h0000, 16'h0002, 0};
        run_instr(nop_v);

        // Reset mid-handshake, with an ack arriving while reset is held.
        imem[1] = 16'h5205;
        run = 1'b1;
        tick();
        check("pre_rst_fetch_req", 16'(fetch_req), 16'h1);
        check("pre_rst_counter", counter, 16'h0002);
        #2 rst = 1'b1;
        #1;
        check("midfetch_rst_counter", counter, 16'h0000);
        check("midfetch_rst_fetch_req", 16'(fetch_req), 16'h0);
        check("midfetch_rst_halted", 16'(halted), 16'h0);
        fetch_ack = 1'b1;
        run = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle_fetch_req", 16'(fetch_req), 16'h0);
        check("post_rst_idle_counter", counter, 16'h0000);
        check("post_rst_ir", 16'(reg_read_address_1), 16'h0);
        fetch_ack = 1'b0;
        run_instr(vecs[0]);

        check("scoreboard_drained", 16'(exp_q.size()), 16'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
